// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, fetches over a req/ack port with at most one
// request in flight, and presents Addr/Ins/valid to the IF/ID register.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned PC_STEP  = 4
) (
  input  logic        clkIn,
  input  logic        resetn,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        stallIn,
  input  logic        redirectIn,
  input  logic [31:0] redirectAddr,
  output logic [31:0] AddrOut,
  output logic [31:0] InsOut,
  output logic        validOut,
  output logic [1:0]  dbg_state_o
);

  // Handshake: a request is live while imem_req=1; it completes in the first cycle
  // that imem_ack=1 with imem_req=1. imem_addr is held for the whole request and a
  // request is never withdrawn, so a redirect during a wait drains it first.
  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_HOLD  = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] redir_q, redir_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] ins_q, ins_d;
  logic        valid_q, valid_d;
  logic [31:0] hold_addr_q, hold_addr_d;
  logic [31:0] hold_ins_q, hold_ins_d;

  logic        ack_seen;
  logic [31:0] target;
  logic [31:0] pc_inc;

  assign imem_req    = resetn && (state_q != ST_HOLD);
  assign imem_addr   = pc_q;
  assign ack_seen    = imem_req && imem_ack;
  assign target      = redirectAddr & ~32'h0000_0003;
  assign pc_inc      = pc_q + 32'(PC_STEP);
  assign AddrOut     = addr_q;
  assign InsOut      = ins_q;
  assign validOut    = valid_q;
  assign dbg_state_o = state_q;

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    redir_d     = redir_q;
    addr_d      = addr_q;
    ins_d       = ins_q;
    valid_d     = valid_q;
    hold_addr_d = hold_addr_q;
    hold_ins_d  = hold_ins_q;

    if (redirectIn) begin
      // Flush beats stall in every state.
      addr_d      = '0;
      ins_d       = '0;
      valid_d     = 1'b0;
      hold_addr_d = '0;
      hold_ins_d  = '0;
    end

    case (state_q)
      ST_FETCH: begin
        if (redirectIn) begin
          if (ack_seen) begin
            pc_d = target;
          end else begin
            redir_d = target;
            state_d = ST_DRAIN;
          end
        end else if (ack_seen) begin
          pc_d = pc_inc;
          if (!stallIn) begin
            addr_d  = pc_q;
            ins_d   = imem_rdata;
            valid_d = 1'b1;
          end else begin
            hold_addr_d = pc_q;
            hold_ins_d  = imem_rdata;
            state_d     = ST_HOLD;
          end
        end else if (!stallIn) begin
          addr_d  = '0;
          ins_d   = '0;
          valid_d = 1'b0;
        end
      end
      ST_HOLD: begin
        if (redirectIn) begin
          pc_d    = target;
          state_d = ST_FETCH;
        end else if (!stallIn) begin
          addr_d  = hold_addr_q;
          ins_d   = hold_ins_q;
          valid_d = 1'b1;
          state_d = ST_FETCH;
        end
      end
      ST_DRAIN: begin
        // The drained word is dropped; the newest pending target wins.
        if (redirectIn) begin
          redir_d = target;
          if (ack_seen) begin
            pc_d    = target;
            state_d = ST_FETCH;
          end
        end else if (ack_seen) begin
          pc_d    = redir_q;
          state_d = ST_FETCH;
        end
      end
      default: state_d = ST_FETCH;
    endcase
  end

  always_ff @(posedge clkIn) begin
    if (!resetn) begin
      state_q     <= ST_FETCH;
      pc_q        <= RESET_PC;
      redir_q     <= '0;
      addr_q      <= '0;
      ins_q       <= '0;
      valid_q     <= 1'b0;
      hold_addr_q <= '0;
      hold_ins_q  <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      redir_q     <= redir_d;
      addr_q      <= addr_d;
      ins_q       <= ins_d;
      valid_q     <= valid_d;
      hold_addr_q <= hold_addr_d;
      hold_ins_q  <= hold_ins_d;
    end
  end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: a cycle table with a hand-driven memory, then scoreboarded
// runs against a wait-state memory model with random ID stalls and a mid-wait reset.
module tb_if_fetch_unit;

  logic        clkIn;
  logic        resetn;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        stallIn;
  logic        redirectIn;
  logic [31:0] redirectAddr;
  logic [31:0] AddrOut;
  logic [31:0] InsOut;
  logic        validOut;
  logic [1:0]  dbg_state;

  if_fetch_unit dut (
    .clkIn        (clkIn),
    .resetn       (resetn),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ack     (imem_ack),
    .imem_rdata   (imem_rdata),
    .stallIn      (stallIn),
    .redirectIn   (redirectIn),
    .redirectAddr (redirectAddr),
    .AddrOut      (AddrOut),
    .InsOut       (InsOut),
    .validOut     (validOut),
    .dbg_state_o  (dbg_state)
  );

  // Clock and reset
  initial clkIn = 1'b0;
  always #5 clkIn = ~clkIn;

  // Memory model: manual ack for the table, otherwise ack after wait_cfg wait cycles.
  logic mem_auto;
  logic man_ack;
  int   wait_cfg;
  int   wait_cnt;

  assign imem_rdata = imem_addr ^ 32'hA5A5_0000;
  assign imem_ack   = mem_auto ? (imem_req && (wait_cnt == wait_cfg)) : man_ack;

  always @(posedge clkIn) begin
    if (!resetn || !imem_req || imem_ack) wait_cnt <= 0;
    else                                  wait_cnt <= wait_cnt + 1;
  end

  // Scoreboard
  logic [31:0] exp_q[$];
  int n_checks;
  int n_fail;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] ins_of(input logic [31:0] a);
    return a ^ 32'hA5A5_0000;
  endfunction

  task automatic push_seq(input logic [31:0] start, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(start + 32'(4 * i));
  endtask

  // Leaves the bench at posedge+1 right after the reset edge.
  task automatic do_reset();
    resetn     = 1'b0;
    stallIn    = 1'b0;
    redirectIn = 1'b0;
    man_ack    = 1'b0;
    #4;
    chk("req_in_reset", {31'b0, imem_req}, 32'h0);
    @(posedge clkIn); #1;
    resetn = 1'b1;
    chk("rst_valid", {31'b0, validOut}, 32'h0);
    chk("rst_addrout", AddrOut, 32'h0);
    chk("rst_insout", InsOut, 32'h0);
    chk("rst_pc", imem_addr, 32'h0);
    chk("rst_state", {30'b0, dbg_state}, 32'h0);
  endtask

  // Runs until the queue drains; an instruction is consumed when valid and not stalled.
  task automatic run_sb(input int max_cycles, input bit rand_stall, output int cycles);
    bit          prev_pend;
    logic [31:0] prev_addr;
    prev_pend = 1'b0;
    prev_addr = '0;
    cycles    = 0;
    while (exp_q.size() > 0 && cycles < max_cycles) begin
      stallIn = rand_stall ? ($urandom_range(0, 2) == 0) : 1'b0;
      #4;
      if (prev_pend) chk("addr_stable", imem_addr, prev_addr);
      prev_pend = imem_req && !imem_ack;
      prev_addr = imem_addr;
      if (!validOut) begin
        chk("bubble_ins", InsOut, 32'h0);
        chk("bubble_addr", AddrOut, 32'h0);
      end else if (!stallIn) begin
        logic [31:0] e;
        e = exp_q.pop_front();
        chk("sb_addr", AddrOut, e);
        chk("sb_ins", InsOut, ins_of(e));
      end
      cycles++;
      @(posedge clkIn); #1;
    end
    stallIn = 1'b0;
    if (exp_q.size() > 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL sb_timeout: got %0d left expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  typedef struct {
    logic        ack;
    logic        stall;
    logic        redir;
    logic [31:0] raddr;
    logic        exp_req;
    logic [31:0] exp_iaddr;
    logic        exp_valid;
    logic [31:0] exp_aout;
    logic [31:0] exp_ins;
  } vec_t;

  vec_t vq[$];

  task automatic addv(input logic ack, input logic stall, input logic redir, input logic [31:0] raddr,
                      input logic ereq, input logic [31:0] eia, input logic ev,
                      input logic [31:0] ea, input logic [31:0] ei);
    vec_t v;
    v.ack = ack; v.stall = stall; v.redir = redir; v.raddr = raddr;
    v.exp_req = ereq; v.exp_iaddr = eia; v.exp_valid = ev; v.exp_aout = ea; v.exp_ins = ei;
    vq.push_back(v);
  endtask

  int cyc;

  initial begin
    n_checks     = 0;
    n_fail       = 0;
    mem_auto     = 1'b0;
    man_ack      = 1'b0;
    wait_cfg     = 0;
    stallIn      = 1'b0;
    redirectIn   = 1'b0;
    redirectAddr = '0;
    resetn       = 1'b0;
    @(posedge clkIn); #1;

    //   ack   stall redir raddr            req   imem_addr       valid AddrOut         InsOut
    addv(1'b1, 1'b0, 1'b0, 32'h0,           1'b1, 32'h0000_0000, 1'b1, 32'h0000_0000, 32'hA5A5_0000);
    addv(1'b1, 1'b0, 1'b0, 32'h0,           1'b1, 32'h0000_0004, 1'b1, 32'h0000_0004, 32'hA5A5_0004);
    addv(1'b1, 1'b1, 1'b0, 32'h0,           1'b1, 32'h0000_0008, 1'b1, 32'h0000_0004, 32'hA5A5_0004);
    addv(1'b0, 1'b1, 1'b0, 32'h0,           1'b0, 32'h0000_000C, 1'b1, 32'h0000_0004, 32'hA5A5_0004);
    addv(1'b0, 1'b1, 1'b0, 32'h0,           1'b0, 32'h0000_000C, 1'b1, 32'h0000_0004, 32'hA5A5_0004);
    addv(1'b0, 1'b0, 1'b0, 32'h0,           1'b0, 32'h0000_000C, 1'b1, 32'h0000_0008, 32'hA5A5_0008);
    addv(1'b1, 1'b0, 1'b0, 32'h0,           1'b1, 32'h0000_000C, 1'b1, 32'h0000_000C, 32'hA5A5_000C);
    addv(1'b0, 1'b0, 1'b0, 32'h0,           1'b1, 32'h0000_0010, 1'b0, 32'h0000_0000, 32'h0000_0000);
    addv(1'b0, 1'b1, 1'b0, 32'h0,           1'b1, 32'h0000_0010, 1'b0, 32'h0000_0000, 32'h0000_0000);
    addv(1'b0, 1'b0, 1'b1, 32'h0000_0103,   1'b1, 32'h0000_0010, 1'b0, 32'h0000_0000, 32'h0000_0000);
    addv(1'b0, 1'b0, 1'b0, 32'h0,           1'b1, 32'h0000_0010, 1'b0, 32'h0000_0000, 32'h0000_0000);
    addv(1'b1, 1'b0, 1'b0, 32'h0,           1'b1, 32'h0000_0010, 1'b0, 32'h0000_0000, 32'h0000_0000);
    addv(1'b1, 1'b0, 1'b0, 32'h0,           1'b1, 32'h0000_0100, 1'b1, 32'h0000_0100, 32'hA5A5_0100);
    addv(1'b1, 1'b1, 1'b0, 32'h0,           1'b1, 32'h0000_0104, 1'b1, 32'h0000_0100, 32'hA5A5_0100);
    addv(1'b0, 1'b1, 1'b1, 32'h0000_0200,   1'b0, 32'h0000_0108, 1'b0, 32'h0000_0000, 32'h0000_0000);
    addv(1'b1, 1'b0, 1'b0, 32'h0,           1'b1, 32'h0000_0200, 1'b1, 32'h0000_0200, 32'hA5A5_0200);
    addv(1'b1, 1'b0, 1'b1, 32'h0000_0300,   1'b1, 32'h0000_0204, 1'b0, 32'h0000_0000, 32'h0000_0000);
    addv(1'b1, 1'b0, 1'b0, 32'h0,           1'b1, 32'h0000_0300, 1'b1, 32'h0000_0300, 32'hA5A5_0300);
    addv(1'b1, 1'b0, 1'b1, 32'hFFFF_FFFF,   1'b1, 32'h0000_0304, 1'b0, 32'h0000_0000, 32'h0000_0000);
    addv(1'b1, 1'b0, 1'b0, 32'h0,           1'b1, 32'hFFFF_FFFC, 1'b1, 32'hFFFF_FFFC, 32'h5A5A_FFFC);
    addv(1'b1, 1'b0, 1'b0, 32'h0,           1'b1, 32'h0000_0000, 1'b1, 32'h0000_0000, 32'hA5A5_0000);

    // Table: hand-driven ack, checked cycle by cycle.
    do_reset();
    foreach (vq[i]) begin
      man_ack      = vq[i].ack;
      stallIn      = vq[i].stall;
      redirectIn   = vq[i].redir;
      redirectAddr = vq[i].raddr;
      #4;
      chk($sformatf("v%0d_req", i), {31'b0, imem_req}, {31'b0, vq[i].exp_req});
      chk($sformatf("v%0d_iaddr", i), imem_addr, vq[i].exp_iaddr);
      @(posedge clkIn); #1;
      chk($sformatf("v%0d_valid", i), {31'b0, validOut}, {31'b0, vq[i].exp_valid});
      chk($sformatf("v%0d_aout", i), AddrOut, vq[i].exp_aout);
      chk($sformatf("v%0d_ins", i), InsOut, vq[i].exp_ins);
    end
    man_ack    = 1'b0;
    stallIn    = 1'b0;
    redirectIn = 1'b0;

    // Zero-wait memory: one instruction per cycle.
    mem_auto = 1'b1;
    wait_cfg = 0;
    do_reset();
    push_seq(32'h0, 8);
    run_sb(100, 1'b0, cyc);
    chk("zero_wait_cycles", 32'(cyc), 32'd9);

    // Two wait states: two bubbles between instructions.
    wait_cfg = 2;
    do_reset();
    push_seq(32'h0, 8);
    run_sb(200, 1'b0, cyc);
    chk("wait2_cycles", 32'(cyc), 32'd25);

    // Random ID stalls with one and zero wait states.
    wait_cfg = 1;
    do_reset();
    push_seq(32'h0, 16);
    run_sb(400, 1'b1, cyc);
    wait_cfg = 0;
    do_reset();
    push_seq(32'h0, 16);
    run_sb(400, 1'b1, cyc);

    // Reset while a request is waiting, then restart from the reset PC.
    wait_cfg = 3;
    do_reset();
    push_seq(32'h0, 2);
    run_sb(100, 1'b0, cyc);
    @(posedge clkIn); #1;
    chk("midwait_req", {31'b0, imem_req}, 32'h1);
    chk("midwait_addr", imem_addr, 32'h0000_0008);
    do_reset();
    push_seq(32'h0, 2);
    run_sb(100, 1'b0, cyc);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/if_fetch_unit.md
Name: if_fetch_unit

Overview:
Instruction-fetch stage. It owns the PC, issues requests to instruction memory over a req/ack handshake, and drives the Addr/Ins pair consumed by the IF/ID pipeline register. It honours the stall from ID and the branch/jump redirect (flush) from later stages. At most one memory request is outstanding at any time.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset (word-aligned).
PC_STEP, 4, PC increment per accepted instruction.

Ports:
clkIn  input  1  clock, rising edge.
resetn  input  1  synchronous, active-low reset.
imem_req  output  1  request valid; held until imem_ack is seen.
imem_addr  output  32  fetch address; equals pc; stable while imem_req=1.
imem_ack  input  1  read data valid this cycle; may be high in the same cycle as imem_req (zero-wait).
imem_rdata  input  32  instruction word, valid when imem_ack=1.
stallIn  input  1  ID stall: hold AddrOut/InsOut/validOut unchanged.
redirectIn  input  1  flush and redirect the PC.
redirectAddr  input  32  new PC; bits [1:0] are ignored and forced to 0.
AddrOut  output  32  PC of the presented instruction (to IF/ID AddrIn).
InsOut  output  32  presented instruction (to IF/ID InsIn); 0 when it is a bubble.
validOut  output  1  AddrOut/InsOut hold a real instruction.

Behaviour:
- Reset (resetn=0 at the clock edge):
  - pc=RESET_PC, state=FETCH.
  - AddrOut=0, InsOut=0, validOut=0, hold buffer empty, imem_req=0 during the reset cycle.
  - Reset mid-request abandons the request; a late ack after reset is ignored until the first post-reset request is issued.
- Combinational outputs: imem_req=1 in FETCH and DRAIN, 0 in HOLD. imem_addr=pc.
- State FETCH:
  - ack=1, stallIn=0: AddrOut<=pc, InsOut<=imem_rdata, validOut<=1, pc<=pc+PC_STEP, stay in FETCH. Throughput is 1 instr/cycle with zero-wait memory.
  - ack=1, stallIn=1: hold buffer<={pc, rdata}, pc<=pc+PC_STEP, go to HOLD. Outputs are unchanged.
  - ack=0, stallIn=0: insert a bubble: validOut<=0, InsOut<=0, AddrOut<=0.
  - ack=0, stallIn=1: outputs unchanged.
- State HOLD (imem_req=0):
  - stallIn=0: buffer moves to the outputs with validOut<=1, go to FETCH.
  - stallIn=1: remain in HOLD.
- State DRAIN: a request was in flight when a redirect came.
  - imem_req stays high with the same address, because a request is never retracted.
  - On ack: discard rdata, go to FETCH. Outputs stay as a bubble.
- Redirect (redirectIn=1) has the highest priority and overrides stallIn in every state:
  - pc<=redirectAddr & ~3, validOut<=0, InsOut<=0, AddrOut<=0, hold buffer invalidated.
  - FETCH with ack=1 this cycle: data discarded, next state FETCH.
  - FETCH with ack=0 while req=1: next state DRAIN, and imem_addr keeps the old address until the drain ack. The new pc is held in a separate redirect register until then.
  - HOLD: next state FETCH.
  - DRAIN: update the pending target, stay in DRAIN.
- pc wraps modulo 2^32: 32'hFFFF_FFFC + 4 = 32'h0000_0000.
- Arithmetic is 32-bit unsigned with no overflow flag.

Test Plan:
- Reset then zero-wait memory (ack tied to req, rdata = addr ^ 32'hA5A5_0000), RESET_PC=0 → AddrOut sequence 0,4,8 on consecutive cycles, validOut=1 from cycle 1, InsOut=32'hA5A5_0004 when AddrOut=4.
- 2-wait-state memory → imem_addr stable during the wait, two bubble cycles (validOut=0, InsOut=0) between instructions, pc increments only on ack.
- stallIn high for 3 cycles while ack arrives for addr 8 → AddrOut stays 4 during the stall; after release AddrOut=8 with no instruction lost or duplicated, then 12.
- redirectIn with redirectAddr=32'h0000_0103 during a wait state → old request drained with its data discarded, next imem_addr=32'h0000_0100, no valid output from the old address.
- redirectIn and stallIn together while in HOLD → flush wins: validOut=0, buffer dropped, fetch resumes at the target.
- pc=32'hFFFF_FFFC, zero-wait → next imem_addr=0. resetn low mid-wait → pc=RESET_PC, validOut=0 the next cycle.
